// File: rtl/io_input_debounce.sv
// +--------------------------------------------------------------------------+
// | io_input_debounce: synchronise/debounce board switches and keys, emit     |
// | key-press strobes and a sticky switch-change flag.       Rev 1.0          |
// +--------------------------------------------------------------------------+
`default_nettype none

module io_input_debounce #(
  parameter int SW_W            = 18,
  parameter int KEY_W           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SW_W-1:0]  sw_in,
  input  logic [KEY_W-1:0] key_in,
  output logic [SW_W-1:0]  sw_out,
  output logic [KEY_W-1:0] key_out,
  output logic [KEY_W-1:0] key_press,
  output logic             io_changed,
  input  logic             io_ack
);

  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

  logic [SW_W-1:0]  r_sw_meta, r_sw_s2, r_sw_s2_q, r_sw_out;
  logic [CNT_W-1:0] r_sw_cnt;
  logic [KEY_W-1:0] r_key_meta, r_key_s2, r_key_s2_q, r_key_out, r_key_press;
  logic [CNT_W-1:0] r_key_cnt [KEY_W];
  logic             r_io_changed;

  logic             w_sw_pending, w_sw_done;
  logic [SW_W-1:0]  w_sw_out_nxt;
  logic [CNT_W-1:0] w_sw_cnt_nxt;
  logic [KEY_W-1:0] w_key_pending, w_key_done, w_key_out_nxt;
  logic [CNT_W-1:0] w_key_cnt_nxt [KEY_W];

  // Shared counter: any switch movement restarts the whole group.
  assign w_sw_pending = (r_sw_s2 == r_sw_s2_q) && (r_sw_s2 != r_sw_out);
  assign w_sw_done    = w_sw_pending && (r_sw_cnt == c_CNT_LAST);
  assign w_sw_out_nxt = w_sw_done ? r_sw_s2 : r_sw_out;
  assign w_sw_cnt_nxt = (w_sw_pending && !w_sw_done) ? r_sw_cnt + c_CNT_ONE : '0;

  for (genvar i = 0; i < KEY_W; i++) begin : g_key
    assign w_key_pending[i] = (r_key_s2[i] == r_key_s2_q[i]) && (r_key_s2[i] != r_key_out[i]);
    assign w_key_done[i]    = w_key_pending[i] && (r_key_cnt[i] == c_CNT_LAST);
    assign w_key_out_nxt[i] = w_key_done[i] ? r_key_s2[i] : r_key_out[i];
    assign w_key_cnt_nxt[i] = (w_key_pending[i] && !w_key_done[i]) ?
                              r_key_cnt[i] + c_CNT_ONE : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_meta    <= '0;
      r_sw_s2      <= '0;
      r_sw_s2_q    <= '0;
      r_sw_out     <= '0;
      r_sw_cnt     <= '0;
      r_key_meta   <= '1;
      r_key_s2     <= '1;
      r_key_s2_q   <= '1;
      r_key_out    <= '1;
      r_key_cnt    <= '{default: '0};
      r_key_press  <= '0;
      r_io_changed <= 1'b0;
    end else begin
      r_sw_meta    <= sw_in;
      r_sw_s2      <= r_sw_meta;
      r_sw_s2_q    <= r_sw_s2;
      r_sw_out     <= w_sw_out_nxt;
      r_sw_cnt     <= w_sw_cnt_nxt;
      r_key_meta   <= key_in;
      r_key_s2     <= r_key_meta;
      r_key_s2_q   <= r_key_s2;
      r_key_out    <= w_key_out_nxt;
      r_key_cnt    <= w_key_cnt_nxt;
      r_key_press  <= r_key_out & ~w_key_out_nxt;
      // A new switch value outranks a simultaneous acknowledge.
      if (w_sw_out_nxt != r_sw_out) begin
        r_io_changed <= 1'b1;
      end else if (io_ack) begin
        r_io_changed <= 1'b0;
      end
    end
  end

  assign sw_out     = r_sw_out;
  assign key_out    = r_key_out;
  assign key_press  = r_key_press;
  assign io_changed = r_io_changed;

endmodule

`default_nettype wire
